// File: rtl/math_pkg.sv
// Opcode encoding, control-state type and per-opcode operand requirements
// shared by the RPN stack calculator and its bench-facing top.
package math_pkg;

  typedef logic [3:0] opcode_t;

  localparam opcode_t OP_NOP   = 4'd0;
  localparam opcode_t OP_PUSH  = 4'd1;
  localparam opcode_t OP_POP   = 4'd2;
  localparam opcode_t OP_DUP   = 4'd3;
  localparam opcode_t OP_SWAP  = 4'd4;
  localparam opcode_t OP_ADD   = 4'd5;
  localparam opcode_t OP_SUB   = 4'd6;
  localparam opcode_t OP_AND   = 4'd7;
  localparam opcode_t OP_OR    = 4'd8;
  localparam opcode_t OP_XOR   = 4'd9;
  localparam opcode_t OP_MUL   = 4'd10;
  localparam opcode_t OP_NEG   = 4'd11;
  localparam opcode_t OP_CLEAR = 4'd12;

  localparam logic [1:0] ARGS_NONE   = 2'd0;
  localparam logic [1:0] ARGS_UNARY  = 2'd1;
  localparam logic [1:0] ARGS_BINARY = 2'd2;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_MUL_WAIT = 1'b1
  } ctrl_state_t;

  // Minimum stack depth an opcode needs before it may execute
  function automatic logic [1:0] op_operands(input opcode_t op);
    case (op)
      OP_POP, OP_DUP, OP_NEG: return ARGS_UNARY;
      OP_SWAP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MUL: return ARGS_BINARY;
      default: return ARGS_NONE;
    endcase
  endfunction

  function automatic logic op_grows(input opcode_t op);
    return (op == OP_PUSH) || (op == OP_DUP);
  endfunction

  function automatic logic op_illegal(input opcode_t op);
    return op > OP_CLEAR;
  endfunction

endpackage

// File: rtl/math_mul_seq.sv
// Sequential shift-add multiplier. Bit 0 of b is consumed on the start edge,
// so done pulses WIDTH-1 edges later and the product is final while done is high.
module math_mul_seq
  import math_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  logic               r_done;

  // Iteration datapath: one multiplier bit per clock while busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc    <= {(2*WIDTH){1'b0}};
      r_mcand  <= {(2*WIDTH){1'b0}};
      r_mplier <= {WIDTH{1'b0}};
      r_cnt    <= {CW{1'b0}};
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else if (start) begin
      r_acc    <= b[0] ? {{WIDTH{1'b0}}, a} : {(2*WIDTH){1'b0}};
      r_mcand  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
      r_mplier <= {1'b0, b[WIDTH-1:1]};
      r_cnt    <= CW'(WIDTH - 1);
      r_busy   <= 1'b1;
      r_done   <= 1'b0;
    end else if (r_busy) begin
      if (r_mplier[0]) begin
        r_acc <= r_acc + r_mcand;
      end else begin
        r_acc <= r_acc;
      end
      r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
      r_cnt    <= r_cnt - CW'(1'b1);
      r_busy   <= (r_cnt != CW'(1'b1));
      r_done   <= (r_cnt == CW'(1'b1));
    end else begin
      r_done <= 1'b0;
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign prod = r_acc;

endmodule

// File: rtl/math_stack_alu.sv
// RPN stack calculator: shift stack with TOS in entry 0, sticky error flag,
// carry flag, and a two-state control FSM that parks in MUL_WAIT during multiplies.
module math_stack_alu
  import math_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           data_in,
  input  logic [3:0]                 op_in,
  input  logic                       op_valid,
  output logic                       op_ready,
  output logic [WIDTH-1:0]           data_out,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       carry,
  output logic                       zero,
  output logic                       err
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam logic [DW-1:0] DEPTH_FULL = DW'(DEPTH);
  localparam logic [DW-1:0] ONE_D      = DW'(1'b1);

  logic [DEPTH-1:0][WIDTH-1:0] r_stack, w_stack_nxt, w_shift_dn, w_shift_up;
  logic [DW-1:0]               r_depth, w_depth_nxt, w_need;
  logic                        r_carry, w_carry_nxt;
  logic                        r_err, w_err_nxt;
  ctrl_state_t                 r_state, w_state_nxt;
  opcode_t                     w_op;
  logic                        w_fault;
  logic                        w_mul_start, w_mul_busy, w_mul_done;
  logic [2*WIDTH-1:0]          w_prod;
  logic [WIDTH:0]              w_sum, w_diff;

  assign w_op   = opcode_t'(op_in);
  assign w_need = DW'(op_operands(w_op));
  assign w_sum  = {1'b0, r_stack[1]} + {1'b0, r_stack[0]};
  assign w_diff = {1'b0, r_stack[1]} - {1'b0, r_stack[0]};
  assign w_fault = op_illegal(w_op) || (r_depth < w_need) ||
                   (op_grows(w_op) && (r_depth == DEPTH_FULL));

  // Stack views shifted toward/away from TOS, zero-filling the vacated end
  always_comb begin
    w_shift_dn = {(DEPTH*WIDTH){1'b0}};
    w_shift_up = {(DEPTH*WIDTH){1'b0}};
    for (int i = 0; i < DEPTH - 1; i++) begin
      w_shift_dn[i]   = r_stack[i+1];
      w_shift_up[i+1] = r_stack[i];
    end
  end

  // Opcode execution and control FSM next state
  always_comb begin
    w_stack_nxt = r_stack;
    w_depth_nxt = r_depth;
    w_carry_nxt = r_carry;
    w_err_nxt   = r_err;
    w_state_nxt = r_state;
    w_mul_start = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!op_valid) begin
          w_state_nxt = ST_IDLE;
        end else if (w_fault) begin
          w_err_nxt = 1'b1;
        end else begin
          case (w_op)
            OP_NOP:  w_stack_nxt = r_stack;
            OP_PUSH: begin
              w_stack_nxt    = w_shift_up;
              w_stack_nxt[0] = data_in;
              w_depth_nxt    = r_depth + ONE_D;
            end
            OP_POP: begin
              w_stack_nxt = w_shift_dn;
              w_depth_nxt = r_depth - ONE_D;
            end
            OP_DUP: begin
              w_stack_nxt    = w_shift_up;
              w_stack_nxt[0] = r_stack[0];
              w_depth_nxt    = r_depth + ONE_D;
            end
            OP_SWAP: begin
              w_stack_nxt[0] = r_stack[1];
              w_stack_nxt[1] = r_stack[0];
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
              w_stack_nxt = w_shift_dn;
              w_depth_nxt = r_depth - ONE_D;
              case (w_op)
                OP_ADD: begin
                  w_stack_nxt[0] = w_sum[WIDTH-1:0];
                  w_carry_nxt    = w_sum[WIDTH];
                end
                OP_SUB: begin
                  w_stack_nxt[0] = w_diff[WIDTH-1:0];
                  w_carry_nxt    = w_diff[WIDTH];
                end
                OP_AND:  w_stack_nxt[0] = r_stack[1] & r_stack[0];
                OP_OR:   w_stack_nxt[0] = r_stack[1] | r_stack[0];
                default: w_stack_nxt[0] = r_stack[1] ^ r_stack[0];
              endcase
            end
            OP_MUL: begin
              w_mul_start = 1'b1;
              w_state_nxt = ST_MUL_WAIT;
            end
            OP_NEG:  w_stack_nxt[0] = -r_stack[0];
            OP_CLEAR: begin
              w_stack_nxt = {(DEPTH*WIDTH){1'b0}};
              w_depth_nxt = {DW{1'b0}};
              w_err_nxt   = 1'b0;
              w_carry_nxt = 1'b0;
            end
            default: w_stack_nxt = r_stack;
          endcase
        end
      end
      ST_MUL_WAIT: begin
        if (w_mul_done) begin
          w_stack_nxt    = w_shift_dn;
          w_stack_nxt[0] = w_prod[WIDTH-1:0];
          w_depth_nxt    = r_depth - ONE_D;
          w_carry_nxt    = |w_prod[2*WIDTH-1:WIDTH];
          w_state_nxt    = ST_IDLE;
        end else if (w_mul_busy) begin
          w_state_nxt = ST_MUL_WAIT;
        end else begin
          // Multiplier lost its job: recover to IDLE and flag it
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Architectural state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stack <= {(DEPTH*WIDTH){1'b0}};
      r_depth <= {DW{1'b0}};
      r_carry <= 1'b0;
      r_err   <= 1'b0;
      r_state <= ST_IDLE;
    end else begin
      r_stack <= w_stack_nxt;
      r_depth <= w_depth_nxt;
      r_carry <= w_carry_nxt;
      r_err   <= w_err_nxt;
      r_state <= w_state_nxt;
    end
  end

  math_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (w_mul_start),
    .a     (r_stack[1]),
    .b     (r_stack[0]),
    .busy  (w_mul_busy),
    .done  (w_mul_done),
    .prod  (w_prod)
  );

  assign op_ready = (r_state == ST_IDLE);
  assign data_out = r_stack[0];
  assign depth    = r_depth;
  assign carry    = r_carry;
  assign zero     = (r_stack[0] == {WIDTH{1'b0}}) && (r_depth != {DW{1'b0}});
  assign err      = r_err;

endmodule

// File: tb/tb_math_stack_alu.sv
// Scoreboard bench: the driver runs a queue-based RPN model at issue time and
// queues expected results; an independent monitor checks each completed op.
module tb_math_stack_alu;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int DW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] data_in;
  logic [3:0]       op_in;
  logic             op_valid;
  logic             op_ready;
  logic [WIDTH-1:0] data_out;
  logic [DW-1:0]    depth;
  logic             carry, zero, err;

  always #5 clk = ~clk;

  math_stack_alu #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .op_in(op_in), .op_valid(op_valid),
    .op_ready(op_ready), .data_out(data_out), .depth(depth), .carry(carry),
    .zero(zero), .err(err)
  );

  typedef struct {
    int unsigned opc;
    int unsigned dout;
    int unsigned dep;
    bit          cy;
    bit          zr;
    bit          er;
    int unsigned busy;
    int unsigned btos;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned m_stack[$];
  bit          m_carry = 1'b0;
  bit          m_err   = 1'b0;
  int unsigned mask    = (32'd1 << WIDTH) - 32'd1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference: front of m_stack is TOS; plain arithmetic on the operands
  task automatic model_op(input int unsigned op, input int unsigned din);
    int unsigned need, s, t, r;
    exp_t e;
    e.opc = op; e.busy = 0; e.btos = 0;
    need = (op == 2 || op == 3 || op == 11) ? 1 : ((op >= 4 && op <= 10) ? 2 : 0);
    if (op > 12 || m_stack.size() < need ||
        ((op == 1 || op == 3) && m_stack.size() == DEPTH)) begin
      m_err = 1'b1;
    end else if (op == 1) begin
      m_stack.push_front(din & mask);
    end else if (op == 2) begin
      void'(m_stack.pop_front());
    end else if (op == 3) begin
      m_stack.push_front(m_stack[0]);
    end else if (op == 4) begin
      t = m_stack.pop_front(); s = m_stack.pop_front();
      m_stack.push_front(t); m_stack.push_front(s);
    end else if (op >= 5 && op <= 10) begin
      t = m_stack.pop_front(); s = m_stack.pop_front();
      case (op)
        5: begin r = s + t; m_carry = (r > mask); end
        6: begin r = s - t; m_carry = (s < t); end
        7: r = s & t;
        8: r = s | t;
        9: r = s ^ t;
        default: begin
          r = s * t; m_carry = ((r >> WIDTH) != 0);
          e.busy = WIDTH; e.btos = t;
        end
      endcase
      m_stack.push_front(r & mask);
    end else if (op == 11) begin
      m_stack[0] = (32'd0 - m_stack[0]) & mask;
    end else if (op == 12) begin
      m_stack.delete(); m_err = 1'b0; m_carry = 1'b0;
    end
    e.dep  = m_stack.size();
    e.dout = (m_stack.size() != 0) ? m_stack[0] : 0;
    e.zr   = (m_stack.size() != 0) && (e.dout == 0);
    e.cy   = m_carry;
    e.er   = m_err;
    sb.push_back(e);
  endtask

  task automatic issue(input int unsigned op, input int unsigned din);
    int n = 0;
    @(negedge clk);
    op_in    = op[3:0];
    data_in  = din[WIDTH-1:0];
    op_valid = 1'b1;
    model_op(op, din);
    while (!op_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!op_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: op_ready=%0b, want 1 for op %0d", op_ready, op);
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    op_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Monitor: busy cycles checked against the in-flight MUL, completions popped
  initial begin
    bit          acc, rdy0;
    int unsigned busy_cnt = 0;
    exp_t        e;
    forever begin
      @(posedge clk);
      acc  = op_valid && op_ready && !rst;
      rdy0 = op_ready;
      #1;
      if (rst) begin
        sb.delete();
        busy_cnt = 0;
      end else if (!op_ready) begin
        busy_cnt++;
        if (sb.size() > 0) chk("busy_tos", data_out, sb[0].btos);
      end else if (acc || !rdy0) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_completion: data_out=0x%0h, want no completion", data_out);
        end else begin
          e = sb.pop_front();
          chk($sformatf("data_out(op%0d)", e.opc), data_out, e.dout);
          chk($sformatf("depth(op%0d)", e.opc), depth, e.dep);
          chk($sformatf("carry(op%0d)", e.opc), carry, e.cy);
          chk($sformatf("zero(op%0d)", e.opc), zero, e.zr);
          chk($sformatf("err(op%0d)", e.opc), err, e.er);
          chk($sformatf("busy_cycles(op%0d)", e.opc), busy_cnt, e.busy);
        end
        busy_cnt = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, want $finish");
    $fatal(1);
  end

  initial begin
    int unsigned op;
    int n;
    rst = 1'b1; op_valid = 1'b0; op_in = 4'd0; data_in = {WIDTH{1'b0}};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data_out", data_out, 0);
    chk("rst_depth", depth, 0);
    chk("rst_err", err, 0);
    chk("rst_carry", carry, 0);
    chk("rst_zero", zero, 0);
    chk("rst_op_ready", op_ready, 1);
    rst = 1'b0;

    issue(1, 'h05); issue(1, 'h03); issue(5, 0);
    issue(1, 'hF0); issue(1, 'h20); issue(5, 0);
    issue(1, 'h10); issue(6, 0); issue(1, 'h01); issue(6, 0);
    issue(12, 0);
    issue(1, 'h12); issue(1, 'h34); issue(10, 0); issue(1, 'h07);
    issue(12, 0);
    issue(2, 0);
    repeat (5) issue(1, 'h01);
    issue(12, 0);

    // Reset three cycles into a multiply
    issue(1, 'h12); issue(1, 'h34); issue(10, 0);
    repeat (3) @(posedge clk);
    #2;
    op_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("async_rst_data_out", data_out, 0);
    chk("async_rst_depth", depth, 0);
    chk("async_rst_carry", carry, 0);
    chk("async_rst_err", err, 0);
    chk("async_rst_op_ready", op_ready, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_stack.delete(); m_carry = 1'b0; m_err = 1'b0;
    issue(1, 'h09);

    issue(14, 0);
    issue(12, 0);
    issue(1, 'h01); issue(1, 'h02); issue(4, 0); issue(11, 0); issue(3, 0); issue(9, 0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) op = 1;
      else if ($urandom_range(0, 29) == 0) op = 12;
      else op = $urandom_range(0, 15);
      issue(op, $urandom);
      if ($urandom_range(0, 7) == 0) idle($urandom_range(0, 3));
    end

    idle(1);
    n = 0;
    while (!op_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
